// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: iterative SHA-256 compression, one round per clock, with feed-forward
module sha256_round (
  input  logic [0:7][31:0] s,
  input  logic [31:0]      k,
  input  logic [31:0]      w,
  output logic [0:7][31:0] s_next
);
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  logic [31:0] t1, t2;
  // one SHA-256 round: T1/T2 then rotate the working variables
  always_comb begin
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    s_next = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  end
endmodule

module sha256_compress_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         use_iv,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  state_t state, state_n;
  logic [5:0] t;
  logic [0:7][31:0] hv, wk, wk_n, ff;
  logic [0:15][31:0] sched;
  logic [31:0] tail;
  logic [255:0] ch;
  sha256_round u_round (.s(wk), .k(K[t]), .w(sched[0]), .s_next(wk_n));
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state and status outputs
  always_comb begin
    state_n = (state == IDLE)  ? (in_valid ? ROUND : IDLE) :
              (state == ROUND) ? ((t == LAST) ? FINAL : ROUND) :
              (state == FINAL) ? DONE : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    busy = (state == ROUND) || (state == FINAL);
    out_valid = state == DONE;
  end
  // chaining value select, schedule tail word and per-word feed-forward sum
  always_comb begin
    ch = use_iv ? IV : hash_in;
    tail = (rotr(sched[14], 17) ^ rotr(sched[14], 19) ^ (sched[14] >> 10)) + sched[9] +
           (rotr(sched[1], 7) ^ rotr(sched[1], 18) ^ (sched[1] >> 3)) + sched[0];
    ff = '0;
    for (int i = 0; i < 8; i++) ff[i] = hv[i] + wk[i];
  end
  // datapath: load on accept, one round per ROUND cycle, digest on FINAL
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      hash_out <= '0;
    end else if (state == IDLE && in_valid) begin
      hv <= ch;
      wk <= ch;
      sched <= block_in;
      t <= '0;
    end else if (state == ROUND) begin
      wk <= wk_n;
      sched <= {sched[1:15], tail};
      t <= t + 6'd1;
    end else if (state == FINAL) begin
      hash_out <= ff;
    end
  end
endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// tb_sha256_compress_ctrl: directed digests checked against a plain SHA-256 model and literals
module tb_sha256_compress_ctrl;
  localparam int ROUNDS = 64;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 0, rst = 1, in_valid = 0, in_ready, use_iv = 0, out_valid, out_ready = 1, busy;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0, hash_out;
  int checks = 0, errors = 0;
  sha256_compress_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .use_iv(use_iv),
    .block_in(block_in), .hash_in(hash_in), .out_valid(out_valid), .out_ready(out_ready),
    .hash_out(hash_out), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  // textbook compression: full 64-word expansion, then the rounds, then feed-forward
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hh [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32 * i -: 32];
      v[i] = hh[i];
    end
    for (int r = 0; r < ROUNDS; r++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32 * i -: 32] = hh[i] + v[i];
    return res;
  endfunction
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  // transaction-level model: idle / computing for ROUNDS+1 edges / holding result
  logic started = 0, m_idle = 1, m_valid = 0;
  int m_cnt = 0;
  logic [255:0] m_pending = '0, m_out = '0;
  always @(posedge clk) begin
    if (rst) begin
      started = 1; m_idle = 1; m_valid = 0; m_cnt = 0; m_out = '0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_idle = 1; end
    end else if (!m_idle) begin
      m_cnt++;
      if (m_cnt == ROUNDS + 1) begin m_valid = 1; m_out = m_pending; end
    end else if (in_valid) begin
      m_idle = 0; m_cnt = 0;
      m_pending = sha_compress(use_iv ? IV : hash_in, block_in);
    end
  end
  // every-cycle compare against the model
  always @(negedge clk) if (started) begin
    chk("in_ready", 256'(in_ready), 256'(m_idle));
    chk("busy", 256'(busy), 256'(!m_idle && !m_valid));
    chk("out_valid", 256'(out_valid), 256'(m_valid));
    chk("hash_out", hash_out, m_out);
  end
  task automatic send(input logic iv, input logic [255:0] h, input logic [511:0] b);
    @(posedge clk); #1;
    in_valid = 1; use_iv = iv; hash_in = h; block_in = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) return;
    end
    chk("out_valid_timeout", 256'(0), 256'(1));
  endtask
  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_hash_out", hash_out, 256'(0));
    chk("model_abc", sha_compress(IV, ABC), ABC_D);
    chk("model_empty", sha_compress(IV, EMPTY), EMPTY_D);
    chk("model_two", sha_compress(sha_compress(IV, B1), B2), TWO_D);
    send(1, '0, ABC);
    wait_out(lat);
    chk("abc_latency", 256'(lat), 256'(ROUNDS + 1));
    chk("abc_digest", hash_out, ABC_D);
    send(1, '0, EMPTY);
    wait_out(lat);
    chk("empty_digest", hash_out, EMPTY_D);
    send(1, '0, B1);
    wait_out(lat);
    send(0, sha_compress(IV, B1), B2);
    wait_out(lat);
    chk("two_block_digest", hash_out, TWO_D);
    @(posedge clk); #1;
    out_ready = 0;
    send(1, '0, ABC);
    wait_out(lat);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 256'(out_valid), 256'(1));
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      chk("bp_hash", hash_out, ABC_D);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 256'(in_ready), 256'(1));
    chk("bp_release_out_valid", 256'(out_valid), 256'(0));
    send(1, '0, EMPTY);
    repeat (30) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_in_ready", 256'(in_ready), 256'(1));
    chk("abort_out_valid", 256'(out_valid), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_hash", hash_out, 256'(0));
    send(1, '0, ABC);
    wait_out(lat);
    chk("after_abort_latency", 256'(lat), 256'(ROUNDS + 1));
    chk("after_abort_digest", hash_out, ABC_D);
    send(1, '0, EMPTY);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      use_iv = ~use_iv;
      block_in = ~block_in ^ {16{32'(i)}};
      hash_in = ~hash_in;
    end
    in_valid = 0;
    wait_out(lat);
    chk("busy_ignore_digest", hash_out, EMPTY_D);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_compress_ctrl.md
Name: sha256_compress_ctrl

Overview:
- Iterative SHA-256 compression controller: accepts one 512-bit message block plus a chaining value, then sequences one sha256_round instance over the rounds, one round per clock.
- Owns the 16-word rolling message schedule, the K-constant ROM, the round counter and the final Davies–Meyer feed-forward add.
- Sits between the padding/block-feeder upstream and the digest collector downstream; valid/ready handshake on both sides.

Parameters:
- ROUNDS, 64, number of compression rounds. Legal range 16..64; only 64 gives standard SHA-256. Reduced values are for debug only.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  block_in/hash_in/use_iv are valid.
- in_ready  out  1  controller idle; input accepted when in_valid && in_ready.
- use_iv  in  1  1: chaining value = standard IV (6a09e667 … 5be0cd19); 0: use hash_in.
- block_in  in  512  message block; [511:480]=W0 … [31:0]=W15 (big-endian word order).
- hash_in  in  256  chaining value; [255:224]=H0 … [31:0]=H7.
- out_valid  out  1  hash_out valid; held until accepted.
- out_ready  in  1  downstream accepts hash_out when out_valid && out_ready.
- hash_out  out  256  updated chaining value, same packing as hash_in.
- busy  out  1  high in ROUND and FINAL.

Behaviour:
- States: IDLE, ROUND, FINAL, DONE.
- Reset (rst=1 at an edge, any state, including mid-round): state=IDLE, round counter=0, in_ready=1, out_valid=0, busy=0, hash_out=0. Working/schedule registers need not be cleared. An in-flight block is discarded and produces no output.
- IDLE: in_ready=1. On accept:
  - latch H0..H7 (IV or hash_in) into the chaining register;
  - load a..h from the same value and W[0..15] from block_in;
  - t=0; go to ROUND. in_ready drops the next cycle.
- ROUND: each cycle drives sha256_round with Kj=K[t] and Wj=sched[0], and registers a..h from its outputs.
  - Schedule shifts left by one word; the new tail word is σ1(sched[14]) + sched[9] + σ0(sched[1]) + sched[0], mod 2^32.
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - t increments; at t==ROUNDS-1 go to FINAL.
- FINAL (1 cycle): hash_out[i] = H[i] + working[i] mod 2^32, with no carry between words. Then DONE, with out_valid=1.
- DONE: out_valid=1 and hash_out stable until out_ready. On the handshake, go to IDLE (in_ready=1 next cycle; hash_out keeps its value).
- Latency: the accept edge is cycle 0; out_valid rises at cycle ROUNDS+1 (65 for 64 rounds). Minimum block period is ROUNDS+3 cycles with out_ready held high.
- Input changes while not in IDLE are ignored. in_valid in DONE is not accepted until IDLE.
- out_ready while out_valid=0 has no effect.
- K ROM is combinational, indexed by t[5:0].
- Only one block is in flight at a time; no internal queueing.

Test Plan:
- "abc" (block 61626380, 14×00000000, 00000018), use_iv=1, out_ready=1 -> out_valid at cycle 65; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (block 80000000, 15×00000000), use_iv=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcde…nopq", two blocks: first with use_iv=1, second with use_iv=0 and hash_in = first result -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> hash_out and out_valid stable, in_ready=0 throughout; accepted on the first out_ready=1 cycle; in_ready=1 the next cycle.
- Reset at round 30 -> next cycle state IDLE, in_ready=1, out_valid=0, busy=0; a following "abc" block yields the correct digest, with no spurious output from the aborted block.
- Toggle in_valid and change block_in while busy -> ignored; digest equals that of the originally accepted block.
